// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin share of the VGA plotter; sweeps a BOX_W x BOX_H block per grant (clip via DRAW_ARB_CLIP_EN)
module vga_draw_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int BOX_W    = 4,
  parameter int BOX_H    = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_x,
  input  logic [7*NUM_REQ-1:0]   req_y,
  input  logic [3*NUM_REQ-1:0]   req_colour,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   busy
);
  localparam int LW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = BOX_W > 1 ? $clog2(BOX_W) : 1;
  localparam int HW = BOX_H > 1 ? $clog2(BOX_H) : 1;
`ifdef DRAW_ARB_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, PLOT, DONE} state_t;
  state_t state, state_d;
  logic [LW-1:0] last, last_d, win;
  logic found;
  logic [CW-1:0] cx, cx_d;
  logic [HW-1:0] cy, cy_d;
  logic [7:0] bx, bx_d, vga_x_d;
  logic [6:0] by, by_d, vga_y_d;
  logic [2:0] col, col_d, vga_colour_d;
  logic fin, fin_d, vga_plot_d, busy_d;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic [8:0] px;
  logic [7:0] py;
  logic col_end, row_end, in_b;
  assign px = {1'b0, bx} + 9'(cx);
  assign py = {1'b0, by} + 8'(cy);
  assign col_end = cx == CW'(BOX_W - 1);
  assign row_end = cy == HW'(BOX_H - 1);
  assign in_b = px < 9'(SCREEN_W) && py < 8'(SCREEN_H);
  always_comb begin
    win = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(last) + k) % NUM_REQ]) begin
        win = LW'((int'(last) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last <= LW'(NUM_REQ - 1);
      cx <= '0;
      cy <= '0;
      bx <= '0;
      by <= '0;
      col <= '0;
      fin <= 1'b0;
      grant <= '0;
      done <= '0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      vga_plot <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      last <= last_d;
      cx <= cx_d;
      cy <= cy_d;
      bx <= bx_d;
      by <= by_d;
      col <= col_d;
      fin <= fin_d;
      grant <= grant_d;
      done <= done_d;
      vga_x <= vga_x_d;
      vga_y <= vga_y_d;
      vga_colour <= vga_colour_d;
      vga_plot <= vga_plot_d;
      busy <= busy_d;
    end
  end
  // fin marks that the last pixel is already in the output register, so PLOT
  // spends one more cycle letting it show before raising done.
  always_comb begin
    state_d = state == IDLE ? (|req ? PLOT : IDLE) :
              state == PLOT ? (fin ? DONE : PLOT) : IDLE;
  end
  always_comb begin
    last_d = last;
    cx_d = cx;
    cy_d = cy;
    bx_d = bx;
    by_d = by;
    col_d = col;
    fin_d = fin;
    grant_d = grant;
    done_d = '0;
    vga_x_d = vga_x;
    vga_y_d = vga_y;
    vga_colour_d = vga_colour;
    vga_plot_d = 1'b0;
    busy_d = busy;
    if (state == IDLE && |req) begin
      grant_d = NUM_REQ'(1) << win;
      busy_d = 1'b1;
      last_d = win;
      bx_d = req_x[8*int'(win) +: 8];
      by_d = req_y[7*int'(win) +: 7];
      col_d = req_colour[3*int'(win) +: 3];
      cx_d = '0;
      cy_d = '0;
      fin_d = 1'b0;
    end
    if (state == PLOT && !fin) begin
      vga_x_d = px[7:0];
      vga_y_d = py[6:0];
      vga_colour_d = col;
      vga_plot_d = !CLIP || in_b;
      cx_d = col_end ? '0 : cx + CW'(1);
      cy_d = col_end ? cy + HW'(1) : cy;
      fin_d = col_end && row_end;
    end
    if (state == PLOT && fin) done_d = grant;
    if (state == DONE) begin
      grant_d = '0;
      busy_d = 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: directed self-checking bench for vga_draw_arbiter
module tb_vga_draw_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] req = '0;
  logic [23:0] req_x = '0;
  logic [20:0] req_y = '0;
  logic [8:0] req_colour = '0;
  logic [2:0] grant, done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic vga_plot, busy;
  int errors = 0;
  int checks = 0;

  vga_draw_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .grant(grant), .done(done), .vga_x(vga_x),
    .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input int r, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    req_x[8*r +: 8] = x;
    req_y[7*r +: 7] = y;
    req_colour[3*r +: 3] = c;
  endtask

  // One full transaction for requester r starting from an idle arbiter.
  task automatic txn(input int r, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                     input bit keep, input bit disturb);
    logic [2:0] oh;
    int ex, ey;
    bit ep;
    oh = 3'(1 << r);
    tick;
    chk("grant", 32'(grant), 32'(oh));
    chk("busy_at_grant", 32'(busy), 1);
    chk("plot_at_grant", 32'(vga_plot), 0);
    for (int i = 0; i < 16; i++) begin
      tick;
      ex = int'(x) + i % 4;
      ey = int'(y) + i / 4;
`ifdef DRAW_ARB_CLIP_EN
      ep = ex < 160 && ey < 120;
`else
      ep = 1'b1;
`endif
      chk("plot", 32'(vga_plot), 32'(ep));
      chk("vga_x", 32'(vga_x), 32'(ex % 256));
      chk("vga_y", 32'(vga_y), 32'(ey % 128));
      chk("colour", 32'(vga_colour), 32'(c));
      chk("grant_hold", 32'(grant), 32'(oh));
      chk("no_done", 32'(done), 0);
      if (disturb && i == 2) begin
        req[r] = 1'b0;
        req_x[8*r +: 8] = 8'd50;
        req_y[7*r +: 7] = 7'd99;
      end
    end
    tick;
    chk("done", 32'(done), 32'(oh));
    chk("grant_in_done", 32'(grant), 32'(oh));
    chk("plot_in_done", 32'(vga_plot), 0);
    chk("busy_in_done", 32'(busy), 1);
    if (!keep) req[r] = 1'b0;
    tick;
    chk("done_clear", 32'(done), 0);
    chk("grant_clear", 32'(grant), 0);
    chk("busy_clear", 32'(busy), 0);
  endtask

  initial begin
    tick;
    tick;
    reset = 1'b0;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_x", 32'(vga_x), 0);
    chk("rst_y", 32'(vga_y), 0);
    chk("rst_colour", 32'(vga_colour), 0);
    tick;
    chk("idle_grant", 32'(grant), 0);
    chk("idle_plot", 32'(vga_plot), 0);
    // single rocket block
    setup(0, 8'd10, 7'd20, 3'd7);
    req = 3'b001;
    txn(0, 8'd10, 7'd20, 3'd7, 0, 0);
    // fresh pointer: all three pending -> 0,1,2
    reset = 1'b1;
    tick;
    reset = 1'b0;
    setup(0, 8'd1, 7'd2, 3'd1);
    setup(1, 8'd40, 7'd50, 3'd2);
    setup(2, 8'd100, 7'd60, 3'd4);
    req = 3'b111;
    txn(0, 8'd1, 7'd2, 3'd1, 0, 0);
    txn(1, 8'd40, 7'd50, 3'd2, 0, 0);
    txn(2, 8'd100, 7'd60, 3'd4, 0, 0);
    // 0 and 2 held continuously alternate
    req = 3'b101;
    txn(0, 8'd1, 7'd2, 3'd1, 1, 0);
    txn(2, 8'd100, 7'd60, 3'd4, 1, 0);
    txn(0, 8'd1, 7'd2, 3'd1, 1, 0);
    txn(2, 8'd100, 7'd60, 3'd4, 1, 0);
    req = 3'b000;
    // mid-transaction drop and base change are ignored
    setup(1, 8'd30, 7'd40, 3'd5);
    req = 3'b010;
    txn(1, 8'd30, 7'd40, 3'd5, 0, 1);
    tick;
    chk("idle_after_drop", 32'(grant), 0);
    // reset on the 5th plot cycle
    setup(0, 8'd70, 7'd80, 3'd6);
    req = 3'b001;
    tick;
    chk("abort_grant", 32'(grant), 3'b001);
    for (int i = 0; i < 5; i++) tick;
    chk("abort_plot_before", 32'(vga_plot), 1);
    chk("abort_x_before", 32'(vga_x), 70);
    chk("abort_y_before", 32'(vga_y), 81);
    reset = 1'b1;
    tick;
    chk("abort_plot", 32'(vga_plot), 0);
    chk("abort_grant_clear", 32'(grant), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    reset = 1'b0;
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_no_done", 32'(done), 0);
    end
    setup(2, 8'd5, 7'd6, 3'd3);
    req = 3'b100;
    txn(2, 8'd5, 7'd6, 3'd3, 0, 0);
    // screen edge: clipped or plotted depending on build
    setup(0, 8'd158, 7'd118, 3'd2);
    req = 3'b001;
    txn(0, 8'd158, 7'd118, 3'd2, 0, 0);
    // coordinate wrap at the top of the range
    setup(1, 8'd254, 7'd126, 3'd6);
    req = 3'b010;
    txn(1, 8'd254, 7'd126, 3'd6, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
Shares the single VGA pixel plotter between the sprite datapaths (rocket, shots, aliens). Each requester presents a base coordinate and colour for a BOX_W x BOX_H block (draw or erase). The arbiter grants one requester at a time in round-robin order and sweeps the block pixel by pixel onto the plotter port. It then returns a one-cycle done pulse to the granted requester.

Parameters:
NUM_REQ, 3, number of requesters; index 0 is rocket, 1 is shots, 2 is aliens.
BOX_W, 4, block width in pixels; range 1..16.
BOX_H, 4, block height in pixels; range 1..16.
SCREEN_W, 160, visible width; used only by the clip feature.
SCREEN_H, 120, visible height; used only by the clip feature.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
req  in  NUM_REQ  per-requester draw request; level, held until done.
req_x  in  8*NUM_REQ  base x; requester i uses bits [8i+7:8i].
req_y  in  7*NUM_REQ  base y; requester i uses bits [7i+6:7i].
req_colour  in  3*NUM_REQ  colour; 3'b000 erases.
grant  out  NUM_REQ  one-hot; the current owner; high for the whole transaction.
done  out  NUM_REQ  one-cycle pulse to the owner after its last pixel.
vga_x  out  8  pixel x to the plotter.
vga_y  out  7  pixel y to the plotter.
vga_colour  out  3  pixel colour to the plotter.
vga_plot  out  1  plotter write enable.
busy  out  1  high from grant through the done cycle.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- All outputs are registered. On reset: grant=0, done=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, state=IDLE, cx=cy=0.
- On reset, the round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, PLOT, DONE.
- IDLE, when no req is high: outputs hold at idle values (vga_plot=0, grant=0).
- IDLE, when any req is high:
  - The winner is the first asserted index searching last+1, last+2, ... modulo NUM_REQ.
  - In the same edge: latch the winner's x, y and colour; set grant[winner]=1 and busy=1; set last=winner; cx=cy=0; go to PLOT.
- PLOT, each cycle:
  - vga_x = (bx+cx) mod 256 and vga_y = (by+cy) mod 128, using natural width truncation.
  - vga_colour = latched colour; vga_plot=1.
  - Scan is row-major: cx increments; at cx=BOX_W-1, cx returns to 0 and cy increments.
  - After pixel (BOX_W-1, BOX_H-1) is issued, go to DONE.
  - Exactly BOX_W*BOX_H plot cycles are issued.
- Latency: req is sampled high at edge N; the first vga_plot=1 appears after edge N+1.
- DONE, one cycle:
  - done[winner]=1, vga_plot=0, grant still asserted.
  - On the next edge: grant=0, busy=0, done=0, return to IDLE.
  - New arbitration starts in IDLE, so there is a minimum of one idle cycle between transactions.
- Latching: base x, y and colour are latched only at grant. Changes to req_x, req_y or req_colour mid-transaction are ignored.
- Requester drops req mid-PLOT: the transaction still completes all pixels and the done pulse.
- Requester keeps req high after done: it is eligible again, but the round-robin pointer gives other pending requesters priority.
- Reset asserted mid-transaction: on the next edge all outputs return to reset values. No done pulse is issued for the aborted transaction.
- Requests are never queued internally. A requester must hold req high until it is serviced.

Optional Feature:
Macro name: DRAW_ARB_CLIP_EN.
- Defined: a pixel with (bx+cx) >= SCREEN_W or (by+cy) >= SCREEN_H is computed before mod wrap. For such a pixel, vga_plot=0 for that cycle, but the scan still spends the cycle. Transaction length stays BOX_W*BOX_H cycles.
- Not defined: no clipping; coordinates wrap mod 256 / mod 128 and every scan cycle plots.

Test Plan:
- Reset, then req[0]=1 with x=10, y=20, colour=7 (BOX 4x4) -> grant=001 next cycle. 16 consecutive plots cover (10..13, 20..23) in row-major order. done[0] pulses the cycle after the last plot; busy falls one cycle later.
- After reset, req=111 held until each requester's done -> service order is 0,1,2, each 16 plots. Each done pulse goes only to its owner.
- req[0] and req[2] held continuously, re-asserted after done -> grants alternate 0,2,0,2. Requester 1 is never granted.
- req[1] dropped and req_x changed to 50 on the 3rd plot cycle -> all 16 pixels still use the latched base; done[1] still pulses.
- reset asserted on the 5th plot cycle -> next cycle vga_plot=0, grant=0, busy=0, and no done pulse. A following req[2] is granted normally.
- x=158, y=118 -> with DRAW_ARB_CLIP_EN: 16 scan cycles with plots only at x in {158,159}, y in {118,119} (4 plots). Without it: 16 plots, x=158..161 and y=118..121.
